// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: debug run/step/stop gating, load-use stall,
// jump flush and halt drain. Control outputs are Mealy on state plus inputs.
module hazard_controller #(
  parameter int MEM_ADDR_SIZE = 5,
  parameter int DRAIN_CYCLES  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_dbg_run,
  input  logic                     i_dbg_step,
  input  logic                     i_dbg_stop,
  input  logic                     i_id_ex_mem_rd,
  input  logic [MEM_ADDR_SIZE-1:0] i_id_ex_rt,
  input  logic [MEM_ADDR_SIZE-1:0] i_if_id_rs,
  input  logic [MEM_ADDR_SIZE-1:0] i_if_id_rt,
  input  logic                     i_jmp_taken,
  input  logic                     i_halt,
  output logic                     o_pipe_en,
  output logic                     o_pc_en,
  output logic                     o_if_id_en,
  output logic                     o_if_id_flush,
  output logic                     o_id_ex_bubble,
  output logic                     o_halted,
  output logic [2:0]               o_state
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_use;

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign load_use = i_id_ex_mem_rd && (i_id_ex_rt != '0) &&
                    ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    o_pipe_en      = 1'b0;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_halted       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_dbg_run) begin
          state_d = RUN;
        end else if (i_dbg_step) begin
          state_d = STEP;
        end
      end

      RUN, STEP: begin
        o_pipe_en = 1'b1;
        // Stall outranks jump and halt; both are re-evaluated once it clears.
        if (load_use) begin
          o_id_ex_bubble = 1'b1;
        end else if (i_jmp_taken) begin
          o_pc_en       = 1'b1;
          o_if_id_en    = 1'b1;
          o_if_id_flush = 1'b1;
        end else if (!i_halt) begin
          o_pc_en    = 1'b1;
          o_if_id_en = 1'b1;
        end

        if (i_halt && !load_use) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else if (state_q == STEP) begin
          state_d = IDLE;
        end else if (i_dbg_stop) begin
          state_d = IDLE;
        end
      end

      DRAIN: begin
        o_pipe_en      = 1'b1;
        o_id_ex_bubble = 1'b1;
        if (cnt_q == '0) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      HALTED: begin
        o_halted = 1'b1;
        cnt_d    = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized checks of hazard_controller against a cycle-level
// behavioural model (mode plus remaining drain cycles).
module tb_hazard_controller;

  localparam int AW    = 5;
  localparam int DRAIN = 4;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_dbg_run, i_dbg_step, i_dbg_stop;
  logic          i_id_ex_mem_rd;
  logic [AW-1:0] i_id_ex_rt, i_if_id_rs, i_if_id_rt;
  logic          i_jmp_taken, i_halt;
  logic          o_pipe_en, o_pc_en, o_if_id_en, o_if_id_flush;
  logic          o_id_ex_bubble, o_halted;
  logic [2:0]    o_state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode uses the documented encodings, left counts the
  // drain cycles still to be spent (including the current one).
  int m_st   = 0;
  int m_left = 0;

  hazard_controller #(.MEM_ADDR_SIZE(AW), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_dbg_run(i_dbg_run), .i_dbg_step(i_dbg_step), .i_dbg_stop(i_dbg_stop),
    .i_id_ex_mem_rd(i_id_ex_mem_rd), .i_id_ex_rt(i_id_ex_rt),
    .i_if_id_rs(i_if_id_rs), .i_if_id_rt(i_if_id_rt),
    .i_jmp_taken(i_jmp_taken), .i_halt(i_halt),
    .o_pipe_en(o_pipe_en), .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_bubble(o_id_ex_bubble),
    .o_halted(o_halted), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [8:0] obs();
    return {o_pipe_en, o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_bubble,
            o_halted, o_state};
  endfunction

  function automatic bit lu();
    return i_id_ex_mem_rd && (i_id_ex_rt != 0) &&
           (i_id_ex_rt == i_if_id_rs || i_id_ex_rt == i_if_id_rt);
  endfunction

  // Expected {pipe,pc,ifid,flush,bubble,halted,state} for model mode + inputs.
  function automatic logic [8:0] exp_vec();
    logic pipe, pc, ifid, fl, bub, hl;
    pipe = 0; pc = 0; ifid = 0; fl = 0; bub = 0; hl = 0;
    if (m_st == 1 || m_st == 2) begin
      pipe = 1;
      if (lu()) bub = 1;
      else if (i_jmp_taken) begin pc = 1; ifid = 1; fl = 1; end
      else if (!i_halt) begin pc = 1; ifid = 1; end
    end else if (m_st == 3) begin
      pipe = 1; bub = 1;
    end else if (m_st == 4) begin
      hl = 1;
    end
    return {pipe, pc, ifid, fl, bub, hl, 3'(m_st)};
  endfunction

  task automatic model_edge();
    bit h;
    h = i_halt && !lu();
    case (m_st)
      0: if (i_dbg_run) m_st = 1; else if (i_dbg_step) m_st = 2;
      1: if (h) begin m_st = 3; m_left = DRAIN; end
         else if (i_dbg_stop) m_st = 0;
      2: if (h) begin m_st = 3; m_left = DRAIN; end else m_st = 0;
      3: begin m_left--; if (m_left == 0) m_st = 4; end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic set_in(input bit run, input bit stp, input bit stop, input bit mrd,
                        input int rt, input int rs, input int frt,
                        input bit jmp, input bit hlt);
    i_dbg_run = run; i_dbg_step = stp; i_dbg_stop = stop;
    i_id_ex_mem_rd = mrd; i_id_ex_rt = AW'(rt); i_if_id_rs = AW'(rs);
    i_if_id_rt = AW'(frt); i_jmp_taken = jmp; i_halt = hlt;
  endtask

  // Called at posedge+1 with inputs already driven; ends at next posedge+1.
  task automatic step(input string tag);
    @(negedge i_clk);
    chk(tag, obs(), exp_vec());
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset(input string tag);
    #2;
    i_reset = 1'b0;
    #1;
    chk(tag, obs(), 9'b0);
    m_st = 0; m_left = 0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
  endtask

  initial begin
    i_reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_outputs", obs(), 9'b0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;

    for (int i = 0; i < 10; i++) step("idle_quiet");
    chk("idle_state", {6'b0, o_state}, 9'd0);

    // Enter RUN, then load-use stall and the rt=0 exemption.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step("go_run");
    chk("run_state", {6'b0, o_state}, 9'd1);
    set_in(0, 0, 0, 1, 8, 8, 1, 0, 0); step("lu_stall");
    set_in(0, 0, 0, 1, 8, 8, 1, 0, 0);
    #1 chk("lu_bubble", {8'b0, o_id_ex_bubble}, 9'd1);
    chk("lu_pc_en", {8'b0, o_pc_en}, 9'd0);
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0); step("rt0_no_stall");

    // Stall beats jump, jump then taken once the dependency clears.
    set_in(0, 0, 0, 1, 3, 1, 3, 1, 0); step("stall_over_jump");
    set_in(0, 0, 0, 1, 3, 1, 2, 1, 0); step("jump_after_stall");
    set_in(0, 0, 0, 1, 3, 1, 3, 1, 1); step("stall_over_halt");
    chk("still_run", {6'b0, o_state}, 9'd1);

    // Halt and stop together: drain wins, stop/run ignored during drain.
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 1); step("halt_stop");
    for (int i = 0; i < DRAIN; i++) begin
      chk("drain_state", {6'b0, o_state}, 9'd3);
      set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
      step("drain_cycle");
    end
    chk("halted_state", {6'b0, o_state}, 9'd4);
    chk("halted_flag", {8'b0, o_halted}, 9'd1);
    for (int i = 0; i < 3; i++) step("halted_ignores_run");

    // Single step from IDLE, then run+step together.
    async_reset("reset_from_halted");
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); step("step_pulse");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("step_pipe_en", {8'b0, o_pipe_en}, 9'd1);
    step("step_active");
    chk("step_back_idle", {6'b0, o_state}, 9'd0);
    step("after_step");
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0); step("run_and_step");
    chk("run_wins", {6'b0, o_state}, 9'd1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step("running");
    async_reset("reset_mid_run");

    // Randomized traffic; registers drawn from a small pool to force matches.
    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(7) == 0,
             1'($urandom_range(1)), $urandom_range(3), $urandom_range(3),
             $urandom_range(3), $urandom_range(4) == 0, $urandom_range(11) == 0);
      if ((m_st == 4 || m_st == 3 || m_st == 2) && $urandom_range(9) == 0)
        async_reset("rnd_reset");
      else
        step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
